// File: rtl/nios_pio_pkg.sv
// Shared definitions for the Nios output PIO: register word offsets,
// status bit positions and the pulse timer state type.
package nios_pio_pkg;

  localparam logic [2:0] ADDR_DATA  = 3'd0;
  localparam logic [2:0] ADDR_SET   = 3'd1;
  localparam logic [2:0] ADDR_CLR   = 3'd2;
  localparam logic [2:0] ADDR_TGL   = 3'd3;
  localparam logic [2:0] ADDR_PLEN  = 3'd4;
  localparam logic [2:0] ADDR_PULSE = 3'd5;
  localparam logic [2:0] ADDR_STAT  = 3'd6;

  localparam int STAT_BUSY_BIT = 0;

  // The timer is IDLE whenever its count is zero, ACTIVE otherwise.
  typedef enum logic {
    TMR_IDLE   = 1'b0,
    TMR_ACTIVE = 1'b1
  } tmr_state_e;

endpackage

// File: rtl/nios_pio_pulse_timer.sv
// One-shot pulse generator shared by all PIO bits. A trigger ORs its mask
// into the active set and (re)loads the length; the whole set drops together
// when the count runs out.
module nios_pio_pulse_timer
  import nios_pio_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int PULSE_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   trig,
  input  logic [WIDTH-1:0]       trig_mask,
  input  logic [PULSE_CNT_W-1:0] plen,
  output logic [WIDTH-1:0]       mask,
  output logic                   busy
);

  localparam logic [PULSE_CNT_W-1:0] CNT_ONE = PULSE_CNT_W'(1);

  logic [PULSE_CNT_W-1:0] cnt;
  logic [PULSE_CNT_W-1:0] cnt_nxt;
  logic [WIDTH-1:0]       mask_nxt;
  logic [PULSE_CNT_W-1:0] load_len;
  tmr_state_e             state;

  // Next count/mask: an effective trigger wins over the decrement, so a
  // retrigger on the last active cycle keeps the accumulated bits.
  always_comb begin
    state    = (cnt != '0) ? TMR_ACTIVE : TMR_IDLE;
    load_len = (plen == '0) ? CNT_ONE : plen;
    cnt_nxt  = cnt;
    mask_nxt = mask;
    if (trig && (trig_mask != '0)) begin
      mask_nxt = mask | trig_mask;
      cnt_nxt  = load_len;
    end else if (state == TMR_ACTIVE) begin
      cnt_nxt = cnt - CNT_ONE;
      if (cnt == CNT_ONE) begin
        mask_nxt = '0;
      end
    end
  end

  // Timer state registers, cleared immediately on reset even mid-pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt  <= '0;
      mask <= '0;
    end else begin
      cnt  <= cnt_nxt;
      mask <= mask_nxt;
    end
  end

  assign busy = (state == TMR_ACTIVE);

endmodule

// File: rtl/nios_pio_out_ext.sv
// Avalon-MM output PIO slave (s1): WIDTH-bit level register with atomic
// set/clear/toggle, plus a shared one-shot pulse that ORs onto the pins.
module nios_pio_out_ext
  import nios_pio_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int               PULSE_CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port,
  output logic             pulse_busy
);

  logic                   wr;
  logic [WIDTH-1:0]       wd;
  logic [WIDTH-1:0]       data;
  logic [PULSE_CNT_W-1:0] plen;
  logic [WIDTH-1:0]       mask;
  logic                   busy;
  logic                   pulse_trig;
  logic                   unused_bits;

  assign wr          = chipselect & ~write_n;
  assign wd          = writedata[WIDTH-1:0];
  assign pulse_trig  = wr && (address == ADDR_PULSE);
  // Upper writedata bits beyond the register widths are deliberately ignored.
  assign unused_bits = &{1'b0, writedata};

  // Level data and pulse-length registers, written through the bus decode.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data <= RESET_VALUE;
      plen <= '0;
    end else if (wr) begin
      case (address)
        ADDR_DATA: data <= wd;
        ADDR_SET:  data <= data | wd;
        ADDR_CLR:  data <= data & ~wd;
        ADDR_TGL:  data <= data ^ wd;
        ADDR_PLEN: plen <= writedata[PULSE_CNT_W-1:0];
        default:   ;
      endcase
    end
  end

  nios_pio_pulse_timer #(
    .WIDTH       (WIDTH),
    .PULSE_CNT_W (PULSE_CNT_W)
  ) u_pulse_timer (
    .clk       (clk),
    .reset_n   (reset_n),
    .trig      (pulse_trig),
    .trig_mask (wd),
    .plen      (plen),
    .mask      (mask),
    .busy      (busy)
  );

  // Zero-latency read mux; write-only and reserved offsets read as zero.
  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA:  readdata[WIDTH-1:0]       = data;
      ADDR_PLEN:  readdata[PULSE_CNT_W-1:0] = plen;
      ADDR_PULSE: readdata[WIDTH-1:0]       = mask;
      ADDR_STAT:  readdata[STAT_BUSY_BIT]   = busy;
      default:    ;
    endcase
  end

  assign out_port   = data | mask;
  assign pulse_busy = busy;

endmodule

// File: tb/tb_nios_pio_out_ext.sv
// Self-checking bench for nios_pio_out_ext: directed scenarios followed by
// random bus traffic, compared each cycle against a cycle-count reference.
module tb_nios_pio_out_ext;

  localparam int         WIDTH = 8;
  localparam int         PCW   = 6;
  localparam logic [7:0] RV    = 8'hA5;

  logic        clk;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [7:0]  out_port;
  logic        pulse_busy;

  nios_pio_out_ext #(
    .WIDTH       (WIDTH),
    .RESET_VALUE (RV),
    .PULSE_CNT_W (PCW)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port),
    .pulse_busy (pulse_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference: pulse modelled as an absolute expiry edge number.
  logic [7:0]  m_data;
  logic [7:0]  m_mask;
  int          m_plen;
  longint      m_cyc;
  longint      m_exp;
  logic [31:0] last_rd;

  function automatic void m_reset();
    m_data = RV;
    m_mask = 8'h00;
    m_plen = 0;
    m_exp  = m_cyc;
  endfunction

  function automatic void m_edge(bit w, logic [2:0] a, logic [31:0] d);
    m_cyc++;
    if (w) begin
      case (a)
        3'd0: m_data = d[7:0];
        3'd1: m_data = m_data | d[7:0];
        3'd2: m_data = m_data & ~d[7:0];
        3'd3: m_data = m_data ^ d[7:0];
        3'd4: m_plen = int'(d % (32'd1 << PCW));
        3'd5: if (d[7:0] != 8'h00) begin
                m_mask = m_mask | d[7:0];
                m_exp  = m_cyc + ((m_plen == 0) ? 1 : m_plen);
              end
        default: ;
      endcase
    end
    if (m_cyc >= m_exp) m_mask = 8'h00;
  endfunction

  function automatic logic [31:0] m_read(logic [2:0] a);
    case (a)
      3'd0:    return {24'h0, m_data};
      3'd4:    return 32'(m_plen);
      3'd5:    return {24'h0, m_mask};
      3'd6:    return {31'h0, (m_cyc < m_exp)};
      default: return 32'h0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One bus cycle, started just after a falling edge: check the read path,
  // let the rising edge happen, then check the pins against the model.
  task automatic step(input bit cs, input bit wn, input logic [2:0] a, input logic [31:0] d);
    chipselect = cs;
    write_n    = wn;
    address    = a;
    writedata  = d;
    #1;
    last_rd = readdata;
    chk("readdata", readdata, m_read(a));
    @(posedge clk);
    m_edge(cs & ~wn, a, d);
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
    chk("out_port", 32'(out_port), {24'h0, m_data | m_mask});
    chk("pulse_busy", 32'(pulse_busy), 32'(m_cyc < m_exp));
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    step(1'b1, 1'b0, a, d);
  endtask

  task automatic idle();
    step(1'b0, 1'b1, 3'd7, 32'h0);
  endtask

  task automatic rd(input string tag, input logic [2:0] a, input logic [31:0] exp);
    step(1'b1, 1'b1, a, 32'h0);
    chk(tag, last_rd, exp);
  endtask

  initial begin
    int nbusy;
    bit cs, wn;
    logic [2:0]  a;
    logic [31:0] d;

    reset_n    = 1'b0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    address    = 3'd0;
    writedata  = 32'h0;
    m_cyc      = 0;
    m_reset();

    // Reset state
    #12;
    chk("rst_out", 32'(out_port), 32'h000000A5);
    chk("rst_busy", 32'(pulse_busy), 32'h0);
    chk("rst_data_rd", readdata, 32'h000000A5);
    @(negedge clk);
    reset_n = 1'b1;
    rd("rd_data_rst", 3'd0, 32'h000000A5);
    rd("rd_stat_rst", 3'd6, 32'h0);
    rd("rd_plen_rst", 3'd4, 32'h0);

    // Atomic level operations
    wr(3'd0, 32'hFFFF_FF0F); rd("data_wr", 3'd0, 32'h0F);
    wr(3'd1, 32'h0000_0030); rd("data_set", 3'd0, 32'h3F);
    wr(3'd2, 32'h0000_0003); rd("data_clr", 3'd0, 32'h3C);
    wr(3'd3, 32'h0000_00FF); rd("data_tgl", 3'd0, 32'hC3);
    rd("rd_set", 3'd1, 32'h0);
    rd("rd_clr", 3'd2, 32'h0);
    rd("rd_tgl", 3'd3, 32'h0);
    rd("rd_rsvd", 3'd7, 32'h0);

    // Basic pulse, length 5
    wr(3'd0, 32'h0);
    wr(3'd4, 32'd5);
    wr(3'd5, 32'h01);
    chk("pulse_e0", 32'(out_port), 32'h01);
    for (int k = 1; k <= 6; k++) begin
      rd("pulse_stat", 3'd6, (k <= 5) ? 32'h1 : 32'h0);
      chk("pulse_pin", 32'(out_port[0]), (k < 5) ? 32'h1 : 32'h0);
    end

    // Zero length gives a single-cycle pulse
    wr(3'd4, 32'd0);
    wr(3'd5, 32'h02);
    chk("plen0_hi", 32'(out_port), 32'h02);
    idle();
    chk("plen0_lo", 32'(out_port), 32'h00);

    // Empty PULSE write while active leaves expiry alone
    wr(3'd4, 32'd3);
    wr(3'd5, 32'h01);
    wr(3'd5, 32'h00);
    idle();
    chk("noop_hi", 32'(out_port), 32'h01);
    idle();
    chk("noop_lo", 32'(out_port), 32'h00);

    // Retrigger accumulates and reloads
    wr(3'd4, 32'd4);
    wr(3'd5, 32'h01);
    idle();
    wr(3'd5, 32'h04);
    rd("retrig_mask", 3'd5, 32'h05);
    idle();
    idle();
    chk("retrig_hi", 32'(out_port), 32'h05);
    idle();
    chk("retrig_lo", 32'(out_port), 32'h00);

    // Level overlap: clear and plen rewrite during a pulse
    wr(3'd0, 32'h01);
    wr(3'd4, 32'd3);
    wr(3'd5, 32'h01);
    wr(3'd2, 32'h01);
    chk("ovl_clr_hi", 32'(out_port), 32'h01);
    wr(3'd4, 32'd10);
    chk("ovl_plen_hi", 32'(out_port), 32'h01);
    idle();
    chk("ovl_lo", 32'(out_port), 32'h00);

    // Write ignored without chipselect
    step(1'b0, 1'b0, 3'd0, 32'h5A);
    rd("no_cs", 3'd0, 32'h00);

    // Maximum length, upper plen bits dropped
    wr(3'd4, 32'hFFFF_FFFF);
    rd("plen_max", 3'd4, 32'd63);
    wr(3'd5, 32'h80);
    nbusy = int'(pulse_busy);
    for (int k = 0; k < 70; k++) begin
      idle();
      nbusy += int'(pulse_busy);
    end
    chk("max_len", 32'(nbusy), 32'd63);

    // Asynchronous reset in the middle of a pulse
    wr(3'd0, 32'h0F);
    wr(3'd4, 32'd20);
    wr(3'd5, 32'hF0);
    idle();
    address = 3'd0;
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst_mid_out", 32'(out_port), 32'h000000A5);
    chk("rst_mid_busy", 32'(pulse_busy), 32'h0);
    chk("rst_mid_rd", readdata, 32'h000000A5);
    m_reset();
    @(negedge clk);
    reset_n = 1'b1;
    m_exp = m_cyc;
    rd("rst_mid_stat", 3'd6, 32'h0);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      cs = ($urandom_range(0, 7) != 0);
      wn = ($urandom_range(0, 2) == 0);
      a  = 3'($urandom_range(0, 7));
      d  = $urandom;
      if (a == 3'd4 && $urandom_range(0, 3) != 0) d = 32'($urandom_range(0, 7));
      if (a == 3'd5 && $urandom_range(0, 3) == 0) d = d & 32'hFFFF_FF00;
      step(cs, wn, a, d);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/nios_pio_out_ext.md
Name: nios_pio_out_ext

Overview:
- Parametrised Avalon-MM output PIO. Next generation of the single-bit output port: WIDTH-bit output register with atomic set/clear/toggle.
- Adds a one-shot pulse generator with a programmable length, shared by all bits.
- Sits on the Nios system interconnect as a slave, s1. It drives board-level control lines such as ADC start, mux select and strobes.

Parameters:
- WIDTH, 8, output port width (1..32).
- RESET_VALUE, 0, value of the data register at reset (WIDTH bits).
- PULSE_CNT_W, 16, width of the pulse-length register and counter (1..32).

Ports:
- clk  in  1  system clock
- reset_n  in  1  reset
- address  in  3  register word offset
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe
- writedata  in  32  write data
- readdata  out  32  read data, zero-extended
- out_port  out  WIDTH  output pins
- pulse_busy  out  1  high while a pulse is active

Behaviour:
- Clock and reset: reset reset_n, asynchronous, active-low; clock clk. All state is updated on the rising clk edge.
- Write strobe: wr = chipselect & ~write_n.
- Only writedata[WIDTH-1:0] is used for data-type registers. Upper bits are ignored.
- Register map (word offsets):
  - 0 DATA, R/W: data <= wd.
  - 1 SET, W: data <= data | wd. Reads 0.
  - 2 CLEAR, W: data <= data & ~wd. Reads 0.
  - 3 TOGGLE, W: data <= data ^ wd. Reads 0.
  - 4 PULSE_LEN, R/W: plen <= wd[PULSE_CNT_W-1:0].
  - 5 PULSE, W: mask <= mask | wd; cnt <= max(plen,1). Read returns the current mask.
  - 6 STATUS, R: bit0 = pulse_busy. Other bits read 0.
  - 7 reserved: reads 0, writes ignored.
- Read timing:
  - Read latency 0: readdata is combinational from the address and registered state.
  - Reads have no side effects.
- Output: out_port = data | mask, i.e. pulsed bits are ORed onto the level bits.
- pulse_busy = (cnt != 0).
- Pulse timer states: IDLE (cnt==0, mask==0) and ACTIVE (cnt!=0).
  - IDLE -> ACTIVE: a PULSE write with wd[WIDTH-1:0] != 0.
  - ACTIVE, each cycle with no PULSE write: cnt <= cnt-1.
  - ACTIVE -> IDLE: at the edge where cnt==1, cnt <= 0 and mask <= 0 in the same edge.
- Pulse timing:
  - A PULSE write accepted at edge E drives the pulsed bits high from E.
  - They clear at edge E+max(plen,1). Pulse width is exactly max(plen,1) clk cycles.
- Retrigger while ACTIVE:
  - mask accumulates (OR).
  - cnt reloads to max(plen,1). The decrement that cycle is discarded.
  - All masked bits stay high until the new expiry.
- Boundary conditions:
  - PULSE write with wd[WIDTH-1:0]==0: no effect on mask or cnt, even while ACTIVE.
  - plen==0: treated as 1, giving a single-cycle pulse.
  - plen written while ACTIVE: affects only later PULSE writes. The running cnt is unchanged.
  - DATA/SET/CLEAR/TOGGLE writes while ACTIVE: modify data only. The mask still forces its bits high, so CLEAR of a pulsed bit does not drop the pin until expiry.
  - Only one register is written per cycle, by bus protocol. No intra-cycle conflicts exist.
  - cnt is PULSE_CNT_W bits. A reload at the maximum value gives 2^PULSE_CNT_W - 1 cycles.
- Reset, including mid-pulse: data=RESET_VALUE, plen=0, mask=0, cnt=0. Output values are out_port=RESET_VALUE, pulse_busy=0, readdata reflecting reset state. Takes effect immediately (asynchronous).

Decomposition:
- Shared package nios_pio_pkg:
  - register offset constants: ADDR_DATA=0, ADDR_SET=1, ADDR_CLR=2, ADDR_TGL=3, ADDR_PLEN=4, ADDR_PULSE=5, ADDR_STAT=6.
  - STAT_BUSY_BIT=0.
- One natural sub-module, nios_pio_pulse_timer. It holds mask, cnt and the IDLE/ACTIVE logic.
  - Parameters: WIDTH, PULSE_CNT_W.
  - Inputs: trig, trig_mask, plen.
  - Outputs: mask, busy.
- The top level holds the bus decode, the data and plen registers, and the read mux.

Test Plan:
- Reset, then read: RESET_VALUE=8'hA5 -> out_port=8'hA5, read DATA=32'h000000A5, STATUS=0, pulse_busy=0. Assert reset_n mid-pulse -> out_port=8'hA5 and busy=0 immediately.
- Atomic ops: write DATA=8'h0F, SET 8'h30, CLEAR 8'h03, TOGGLE 8'hFF -> DATA reads 8'h0F, 8'h3F, 8'h3C, 8'hC3 respectively. SET/CLEAR/TOGGLE addresses read 0.
- Basic pulse: plen=5, DATA=0, write PULSE=8'h01 at edge E -> out_port[0]=1 for exactly 5 cycles, cleared at E+5. pulse_busy mirrors this. STATUS reads 1 during the pulse and 0 after.
- Zero/no-op cases:
  - plen=0, PULSE=8'h02 -> single-cycle pulse on bit 1.
  - PULSE=0 while ACTIVE -> expiry unchanged.
- Retrigger: plen=4, PULSE=8'h01 at E, PULSE=8'h04 at E+2 -> bits 0 and 2 both high until E+6, then both clear. PULSE read at E+3 = 8'h05.
- Overlap with level: DATA=8'h01, pulse bit0 plen=3, CLEAR 8'h01 during pulse -> out_port[0] stays 1 until expiry, then 0. Write plen=10 mid-pulse -> current pulse still ends at its original expiry.
